// File: rtl/bram_port_arbiter_pkg.sv
// Shared types, defaults and width helpers for the BRAM port arbiter slice.
package bram_port_arbiter_pkg;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_ADDR_W    = 4;

  typedef enum logic {
    CMD_READ  = 1'b0,
    CMD_WRITE = 1'b1
  } cmd_e;

  // Bits needed to encode a requester index; never less than one.
  function automatic int id_width(input int n);
    for (int w = 1; w < 32; w++) begin
      if ((1 << w) >= n) return w;
    end
    return 32;
  endfunction

  function automatic int wrap_inc(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Requester-side bus of the BRAM port arbiter: flattened commands in, grant and read return out.
interface bram_port_arbiter_if
  import bram_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int RAM_DATA_WIDTH = DEF_DATA_W,
  parameter int RAM_ADDR_WIDTH = DEF_ADDR_W
);
  localparam int IW = id_width(NUM_REQ);

  // Handshake: requester i raises req[i] with wr/addr/wdata and holds them stable;
  // the command is taken in the cycle req[i] & gnt[i]. Dropping req before gnt cancels it.
  // Reads return rd_valid[i] (one-hot) with rd_data exactly two cycles after acceptance.
  logic [NUM_REQ-1:0]                req;
  logic [NUM_REQ-1:0]                wr;
  logic [NUM_REQ*RAM_ADDR_WIDTH-1:0] addr;
  logic [NUM_REQ*RAM_DATA_WIDTH-1:0] wdata;
  logic [NUM_REQ-1:0]                gnt;
  logic [NUM_REQ-1:0]                rd_valid;
  logic [RAM_DATA_WIDTH-1:0]         rd_data;
  logic [IW-1:0]                     dbg_ptr;

  modport master (
    output req, wr, addr, wdata,
    input  gnt, rd_valid, rd_data, dbg_ptr
  );

  modport slave (
    input  req, wr, addr, wdata,
    output gnt, rd_valid, rd_data, dbg_ptr
  );

endinterface

// File: rtl/bram_port_arbiter_rr.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, wrapping.
module rr_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = id_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!gnt_any && req[(int'(ptr) + k) % N]) begin
        gnt[(int'(ptr) + k) % N] = 1'b1;
        gnt_idx                  = IW'((int'(ptr) + k) % N);
        gnt_any                  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bram_sync_dp.sv
// Dual-clock synchronous BRAM: port A read/write (read-before-write), port B read-only.
module bram_sync_dp #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          a_clk,
  input  logic          rst,
  input  logic          a_wr,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data_in,
  output logic [DW-1:0] a_data_out,
  input  logic          b_clk,
  input  logic [AW-1:0] b_addr,
  output logic [DW-1:0] b_data_out
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // rst clears only the output register; the array keeps its contents.
  always_ff @(posedge a_clk) begin
    if (rst) a_data_out <= '0;
    else     a_data_out <= mem[a_addr];
    if (a_wr) mem[a_addr] <= a_data_in;
  end

  always_ff @(posedge b_clk) begin
    b_data_out <= mem[b_addr];
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin sharing of one BRAM port: combinational grant, registered issue (S1) and return (S2) stages.
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int RAM_DATA_WIDTH = DEF_DATA_W,
  parameter int RAM_ADDR_WIDTH = DEF_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst,
  bram_port_arbiter_if.slave        bus,
  output logic                      ram_wr,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic [RAM_DATA_WIDTH-1:0] ram_data_in,
  input  logic [RAM_DATA_WIDTH-1:0] ram_data_out
);

  localparam int IW = id_width(NUM_REQ);

  logic [IW-1:0]      ptr;
  logic [IW-1:0]      arb_idx;
  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] arb_gnt;
  logic               arb_any;
  cmd_e               acc_cmd;

  logic               s1_valid, s1_rd;
  logic [IW-1:0]      s1_id;
  logic               s2_valid, s2_rd;
  logic [IW-1:0]      s2_id;
  logic [NUM_REQ-1:0] rd_valid_c;

  // Masking requests during reset keeps gnt low without a separate output gate.
  assign arb_req = rst ? '0 : bus.req;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .req     (arb_req),
    .ptr     (ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  assign bus.gnt     = arb_gnt;
  assign bus.dbg_ptr = ptr;
  assign acc_cmd     = cmd_e'(bus.wr[arb_idx]);

  always_ff @(posedge clk) begin
    if (rst)          ptr <= '0;
    else if (arb_any) ptr <= IW'(wrap_inc(int'(arb_idx), NUM_REQ));
  end

  // S1: drives the BRAM port. Without an accept, addr/data hold and ram_wr drops,
  // so the BRAM performs a harmless read that S2 discards.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_wr      <= 1'b0;
      ram_addr    <= '0;
      ram_data_in <= '0;
      s1_valid    <= 1'b0;
      s1_rd       <= 1'b0;
      s1_id       <= '0;
    end else if (arb_any) begin
      ram_wr      <= (acc_cmd == CMD_WRITE);
      ram_addr    <= bus.addr[int'(arb_idx)*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH];
      ram_data_in <= bus.wdata[int'(arb_idx)*RAM_DATA_WIDTH +: RAM_DATA_WIDTH];
      s1_valid    <= 1'b1;
      s1_rd       <= (acc_cmd == CMD_READ);
      s1_id       <= arb_idx;
    end else begin
      ram_wr      <= 1'b0;
      s1_valid    <= 1'b0;
    end
  end

  // S2 lines up with the BRAM's registered read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_rd    <= 1'b0;
      s2_id    <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_rd    <= s1_rd;
      s2_id    <= s1_id;
    end
  end

  always_comb begin
    rd_valid_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rd_valid_c[i] = s2_valid && s2_rd && (s2_id == IW'(i));
    end
  end

  assign bus.rd_valid = rd_valid_c;
  assign bus.rd_data  = ram_data_out;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench: arbiter plus attached BRAM, port B read by a second-clock agent.
module tb_bram_port_arbiter;
  import bram_port_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int AW = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic b_clk = 1'b0;
  logic rst   = 1'b1;
  always #5 clk   = ~clk;
  always #7 b_clk = ~b_clk;

  bram_port_arbiter_if #(
    .NUM_REQ        (NR),
    .RAM_DATA_WIDTH (DW),
    .RAM_ADDR_WIDTH (AW)
  ) bus ();

  logic          ram_wr;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data_in;
  logic [DW-1:0] ram_data_out;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data_out;

  bram_port_arbiter #(
    .NUM_REQ        (NR),
    .RAM_DATA_WIDTH (DW),
    .RAM_ADDR_WIDTH (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .ram_wr       (ram_wr),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  bram_sync_dp #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .a_clk      (clk),
    .rst        (rst),
    .a_wr       (ram_wr),
    .a_addr     (ram_addr),
    .a_data_in  (ram_data_in),
    .a_data_out (ram_data_out),
    .b_clk      (b_clk),
    .b_addr     (b_addr),
    .b_data_out (b_data_out)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [11:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.req = '0;
    bus.wr  = '0;
  endtask

  task automatic set_cmd(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req[i]             = 1'b1;
    bus.wr[i]              = w;
    bus.addr[i*AW +: AW]   = a;
    bus.wdata[i*DW +: DW]  = d;
  endtask

  task automatic smp(input string tag, input logic [3:0] g, input logic w,
                     input logic [3:0] rv, input logic [7:0] rd);
    @(negedge clk);
    chk({tag, "_gnt"}, 32'(bus.gnt), 32'(g));
    chk({tag, "_ram_wr"}, 32'(ram_wr), 32'(w));
    chk({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'(rv));
    if (rv != 4'd0) chk({tag, "_rd_data"}, 32'(bus.rd_data), 32'(rd));
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    drive_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [11:0] e;
    logic [3:0]  g;

    drive_idle();
    bus.addr  = '0;
    bus.wdata = '0;
    b_addr    = '0;
    rst       = 1'b1;
    bus.req   = '1;

    // Reset: requests present but grant must stay low.
    smp("rst1", 4'b0000, 1'b0, 4'b0000, 8'h00);
    chk("rst1_addr", 32'(ram_addr), 32'h0);
    chk("rst1_din", 32'(ram_data_in), 32'h0);
    chk("rst1_ptr", 32'(bus.dbg_ptr), 32'h0);
    @(posedge clk); #1;
    bus.req = '1;
    smp("rst2", 4'b0000, 1'b0, 4'b0000, 8'h00);
    adv();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      smp("idle", 4'b0000, 1'b0, 4'b0000, 8'h00);
      adv();
    end

    // Single write then read through requester 0.
    set_cmd(0, 1'b1, 4'd3, 8'hA5);
    smp("wr1", 4'b0001, 1'b0, 4'b0000, 8'h00);
    adv();
    set_cmd(0, 1'b0, 4'd3, 8'h00);
    smp("rd1", 4'b0001, 1'b1, 4'b0000, 8'h00);
    chk("rd1_addr", 32'(ram_addr), 32'h3);
    chk("rd1_din", 32'(ram_data_in), 32'hA5);
    adv();
    smp("rd1_s1", 4'b0000, 1'b0, 4'b0000, 8'h00);
    chk("rd1_s1_addr", 32'(ram_addr), 32'h3);
    adv();
    smp("rd1_ret", 4'b0000, 1'b0, 4'b0001, 8'hA5);
    chk("rd1_ptr", 32'(bus.dbg_ptr), 32'h1);
    adv();

    // Preload addr 0..3 with 0x10..0x13 via requester 3 (leaves ptr at 0).
    for (int i = 0; i < 4; i++) begin
      set_cmd(3, 1'b1, AW'(i), DW'(8'h10 + i));
      smp("pre", 4'b1000, (i != 0), 4'b0000, 8'h00);
      adv();
    end

    // Round robin: all four read their own address for 8 cycles.
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        for (int i = 0; i < 4; i++) set_cmd(i, 1'b0, AW'(i), 8'h00);
        g = 4'(1 << (c % 4));
        exp_q.push_back({g, 8'(8'h10 + (c % 4))});
      end else begin
        g = 4'b0000;
      end
      e = (c >= 2) ? exp_q.pop_front() : 12'h000;
      smp("rr", g, (c == 0), e[11:8], e[7:0]);
      adv();
    end
    chk("rr_q_empty", 32'(exp_q.size()), 32'd0);

    // Pointer wrap and skip: grant 2 sets ptr=3, then req {3,0}.
    set_cmd(2, 1'b0, 4'd2, 8'h00);
    smp("skA", 4'b0100, 1'b0, 4'b0000, 8'h00);
    adv();
    set_cmd(3, 1'b0, 4'd3, 8'h00); set_cmd(0, 1'b0, 4'd0, 8'h00);
    smp("skB", 4'b1000, 1'b0, 4'b0000, 8'h00);
    chk("skB_ptr", 32'(bus.dbg_ptr), 32'h3);
    adv();
    set_cmd(3, 1'b0, 4'd3, 8'h00); set_cmd(0, 1'b0, 4'd0, 8'h00);
    smp("skC", 4'b0001, 1'b0, 4'b0100, 8'h12);
    adv();
    set_cmd(3, 1'b0, 4'd3, 8'h00); set_cmd(0, 1'b0, 4'd0, 8'h00);
    smp("skD", 4'b1000, 1'b0, 4'b1000, 8'h13);
    adv();
    smp("skE", 4'b0000, 1'b0, 4'b0001, 8'h10);
    adv();
    smp("skF", 4'b0000, 1'b0, 4'b1000, 8'h13);
    adv();

    // Write by req1 then read by req2 of the same address on the next cycle.
    set_cmd(1, 1'b1, 4'd7, 8'h3C);
    smp("hzN", 4'b0010, 1'b0, 4'b0000, 8'h00);
    adv();
    set_cmd(2, 1'b0, 4'd7, 8'h00);
    smp("hz1", 4'b0100, 1'b1, 4'b0000, 8'h00);
    adv();
    smp("hz2", 4'b0000, 1'b0, 4'b0000, 8'h00);
    adv();
    smp("hz3", 4'b0000, 1'b0, 4'b0100, 8'h3C);
    adv();

    // Reset while a read is in flight: it must be dropped and ptr cleared.
    set_cmd(2, 1'b0, 4'd7, 8'h00);
    smp("mfN", 4'b0100, 1'b0, 4'b0000, 8'h00);
    adv();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) set_cmd(i, 1'b0, 4'd7, 8'h00);
    smp("mf1", 4'b0000, 1'b0, 4'b0000, 8'h00);
    adv();
    rst = 1'b0;
    set_cmd(1, 1'b0, 4'd7, 8'h00); set_cmd(3, 1'b0, 4'd3, 8'h00);
    smp("mf2", 4'b0010, 1'b0, 4'b0000, 8'h00);
    chk("mf2_ptr", 32'(bus.dbg_ptr), 32'h0);
    adv();
    smp("mf3", 4'b0000, 1'b0, 4'b0000, 8'h00);
    adv();
    smp("mf4", 4'b0000, 1'b0, 4'b0010, 8'h3C);
    adv();
    rst = 1'b1;
    smp("mf5", 4'b0000, 1'b0, 4'b0000, 8'h00);
    adv();
    rst = 1'b0;
    set_cmd(3, 1'b0, 4'd3, 8'h00);
    smp("mf6", 4'b1000, 1'b0, 4'b0000, 8'h00);
    adv();
    smp("mf7", 4'b0000, 1'b0, 4'b0000, 8'h00);
    adv();
    smp("mf8", 4'b0000, 1'b0, 4'b1000, 8'h13);
    adv();

    // Port B agent on its own clock sees the contents written through port A.
    b_addr = 4'd7;
    @(posedge b_clk); @(posedge b_clk); #1;
    chk("portb_a7", 32'(b_data_out), 32'h3C);
    b_addr = 4'd1;
    @(posedge b_clk); @(posedge b_clk); #1;
    chk("portb_a1", 32'(b_data_out), 32'h11);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
Round-robin arbiter that shares one port of the dual-port synchronous BRAM among NUM_REQ requesters on a single clock. Each requester issues single-word read or write commands with a req/gnt handshake. The block drives the BRAM port through a registered issue stage. It returns read data with a one-hot per-requester valid, aligned to the BRAM's one-cycle registered read. It sits between client engines (DMA, register bridges) and one BRAM port; the other BRAM port stays free for an independent clock domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
RAM_DATA_WIDTH, 8, data width; matches the attached BRAM
RAM_ADDR_WIDTH, 4, address bits; matches the attached BRAM

Ports:
clk  in  1  single clock; the attached BRAM port clock is tied to it
rst  in  1  reset; synchronous, active-high (shared with the BRAM rst)
req  in  NUM_REQ  per-requester command request
wr  in  NUM_REQ  per-requester 1=write, 0=read
addr  in  NUM_REQ*RAM_ADDR_WIDTH  flattened addresses, requester i at [i*AW +: AW]
wdata  in  NUM_REQ*RAM_DATA_WIDTH  flattened write data, requester i at [i*DW +: DW]
gnt  out  NUM_REQ  one-hot combinational grant; command accepted when req[i]&gnt[i]
rd_valid  out  NUM_REQ  one-hot, read data valid for requester i
rd_data  out  RAM_DATA_WIDTH  read data, broadcast to all requesters
ram_wr  out  1  to BRAM port wr
ram_addr  out  RAM_ADDR_WIDTH  to BRAM port addr
ram_data_in  out  RAM_DATA_WIDTH  to BRAM port data_in
ram_data_out  in  RAM_DATA_WIDTH  from BRAM port data_out

Behaviour:
- Arbitration (combinational): round-robin pointer ptr (log2 NUM_REQ bits).
  - Grant the first asserted req scanning ptr, ptr+1, ... wrapping modulo NUM_REQ.
  - gnt is all-zero when req==0; at most one gnt bit is high.
- Pointer update: on any accepted command from requester i, ptr <= (i+1) mod NUM_REQ. With no grant, ptr holds.
- Throughput: one command accepted every cycle; no bubbles, no backpressure beyond gnt.
- Issue stage S1 (registered), from the command accepted in cycle N, driven during cycle N+1:
  - ram_addr and ram_data_in hold the accepted values.
  - ram_wr=wr_i.
  - s1_valid=1; s1_id=i; s1_rd=~wr_i.
- No accepted command in cycle N: in N+1, ram_wr=0, s1_valid=0, ram_addr/ram_data_in hold their last values.
- Idle reads: with ram_wr=0 the BRAM still performs a harmless read, which is discarded.
- Return stage S2 (registered from S1): s2_valid, s2_id, s2_rd.
  - In cycle N+2: rd_valid[s2_id] = s2_valid & s2_rd; all other bits 0.
  - rd_data = ram_data_out, passed through combinationally.
- Read latency: accept at cycle N gives rd_valid/rd_data in cycle N+2, fixed.
- Writes produce no response. gnt is the only write acknowledgement.
- Hazards:
  - BRAM is read-before-write.
  - A read accepted one cycle after a write to the same address returns the new data: the write is in the BRAM before the read's S1 cycle.
  - A read and write never coexist on this port in the same cycle.
- Reset: rst high at a clock edge forces:
  - ptr=0
  - ram_wr=0, ram_addr=0, ram_data_in=0
  - s1_valid=0, s2_valid=0, so rd_valid=0 next cycle
  - gnt is forced to 0 while rst is high.
- Reset mid-operation: in-flight reads are dropped with no rd_valid. Memory contents are not cleared.
- Requester stability: requester i must hold req/wr/addr/wdata stable until gnt[i]. Dropping req before gnt is permitted and cancels the command.

Decomposition:
- Shared include bram_arb_defs.vh:
  - clog2 function for ptr/id widths
  - field-slice macros for the flattened addr/wdata buses
- Sub-module rr_arbiter, combinational: inputs req and ptr; outputs one-hot gnt and encoded grant index. Reusable elsewhere.
- bram_port_arbiter instantiates rr_arbiter plus the S1/S2 registers and the ptr register.
- Bench instantiates bram_port_arbiter with bram_sync_dp; port B is driven by the bench as a second-clock agent.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 for 2 cycles, then req=0.
  - Required: gnt=0, ram_wr=0, rd_valid=0 throughout.
- Single write then read:
  - Stimulus: req0 writes addr 3 with 0xA5 at cycle 10; req0 reads addr 3 at cycle 11.
  - Required: gnt[0] high at 10 and 11; ram_wr=1 at 11; rd_valid=0001 with rd_data=0xA5 at 13.
- Round-robin fairness:
  - Stimulus: all four req held high for 8 cycles, reads of addr 0..3 preloaded with 0x10..0x13.
  - Required: grant order 0,1,2,3,0,1,2,3.
  - Required: rd_valid order matches grant order, 2 cycles later, with the matching data.
- Pointer wrap/skip:
  - Stimulus: ptr=3 after a grant to req2; req={1,0,0,1} (bits 3,0).
  - Required: grant 3, then 0, then 3.
- Back-to-back write/read same address, different requesters:
  - Stimulus: req1 writes addr 7 with 0x3C, accepted at N; req2 reads addr 7, accepted at N+1.
  - Required: rd_valid[2]=1 and rd_data=0x3C at N+3.
- Reset mid-flight:
  - Stimulus: read accepted at N, rst=1 at N+1.
  - Required: no rd_valid at N+2; ptr=0; after rst deasserts, req3 alone is granted first cycle.
